// File: rtl/i2c_target_regs.sv
// I2C target exposing a register map to local logic.
// An address-matched controller sets a register pointer, then writes register bytes
// (wr_stb pulses) or reads register bytes (shifted out of rd_data).
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   scl_i, sda_i     raw I2C pad inputs (asynchronous)
//   sda_oe           1 = pull SDA low, 0 = release
//   wr_stb           one-clk register write strobe carrying wr_addr/wr_data
//   wr_addr, wr_data register write address and data
//   rd_addr          register being read (always the current pointer)
//   rd_data          contents of rd_addr, valid one clk after rd_addr changes
//   busy             high from an ACKed address match until STOP or a non-matching address
module i2c_target_regs #(
  parameter logic [6:0]  DEV_ADDR = 7'h42,
  parameter int unsigned PTR_W    = 8,
  parameter int unsigned FILT_LEN = 3,
  parameter int unsigned HOLD_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             wr_stb,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic [PTR_W-1:0] rd_addr,
  input  logic [7:0]       rd_data,
  output logic             busy
);

  localparam int unsigned FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned HCNT_W = $clog2(HOLD_CYC + 1);
  localparam int unsigned BCNT_W = 4;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, IGNORE
  } state_t;

  // Index 1 = SCL, index 0 = SDA
  logic [1:0]             sync1, sync2, filt, filt_q;
  logic [1:0][FCNT_W-1:0] fcnt;
  logic [HCNT_W-1:0]      hold_cnt;

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, hold_done;

  state_t            state, state_d;
  logic [BCNT_W-1:0] bit_cnt, bit_cnt_d;
  logic [6:0]        shift, shift_d;
  logic [PTR_W-1:0]  ptr, ptr_d;
  logic              rw, rw_d;
  logic              sda_oe_d, busy_d, wr_stb_d;
  logic [PTR_W-1:0]  wr_addr_d;
  logic [7:0]        wr_data_d;
  logic [7:0]        byte_in;

  // Synchronise both lines, then accept a new level only after FILT_LEN equal samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      filt   <= 2'b11;
      filt_q <= 2'b11;
      fcnt   <= '0;
    end else begin
      sync1  <= {scl_i, sda_i};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FCNT_W'(FILT_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FCNT_W'(1);
        end
      end
    end
  end

  assign scl_f     = filt[1];
  assign sda_f     = filt[0];
  assign scl_rise  = filt[1] & ~filt_q[1];
  assign scl_fall  = ~filt[1] & filt_q[1];
  assign start_det = filt[1] & filt_q[1] & filt_q[0] & ~filt[0];
  assign stop_det  = filt[1] & filt_q[1] & ~filt_q[0] & filt[0];

  // SDA hold timer: hold_done fires HOLD_CYC clk after each filtered SCL fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (scl_fall) begin
      hold_cnt <= HCNT_W'(HOLD_CYC);
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - HCNT_W'(1);
    end
  end

  assign hold_done = (hold_cnt == HCNT_W'(1));
  assign byte_in   = {shift, sda_f};

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      ptr     <= '0;
      rw      <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      shift   <= shift_d;
      ptr     <= ptr_d;
      rw      <= rw_d;
      sda_oe  <= sda_oe_d;
      busy    <= busy_d;
      wr_stb  <= wr_stb_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
    end
  end

  assign rd_addr = ptr;

  // Next-state and next-output logic; STOP and START override everything
  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    shift_d   = shift;
    ptr_d     = ptr;
    rw_d      = rw;
    sda_oe_d  = sda_oe;
    busy_d    = busy;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;

    if (stop_det) begin
      state_d   = IDLE;
      busy_d    = 1'b0;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
    end else if (start_det) begin
      state_d   = ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
    end else begin
      case (state)
        IDLE: begin
          sda_oe_d = 1'b0;
        end

        ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt + BCNT_W'(1);
            if (bit_cnt == BCNT_W'(7)) begin
              bit_cnt_d = '0;
              rw_d      = sda_f;
              if (byte_in[7:1] == DEV_ADDR) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = IGNORE;
                busy_d  = 1'b0;
              end
            end
          end
        end

        // First hold_done (after 8th fall) asserts ACK, second (after 9th fall) ends it
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (hold_done) begin
            if (!sda_oe) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              if (state == ADDR_ACK && rw) begin
                shift_d  = rd_data[6:0];
                sda_oe_d = ~rd_data[7];
                state_d  = RDATA;
              end else if (state == ADDR_ACK) begin
                state_d = PTR;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end

        PTR: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt + BCNT_W'(1);
            if (bit_cnt == BCNT_W'(7)) begin
              bit_cnt_d = '0;
              ptr_d     = PTR_W'(byte_in);
              state_d   = PTR_ACK;
            end
          end
        end

        WDATA: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt + BCNT_W'(1);
            if (bit_cnt == BCNT_W'(7)) begin
              bit_cnt_d = '0;
              wr_stb_d  = 1'b1;
              wr_addr_d = ptr;
              wr_data_d = byte_in;
              ptr_d     = ptr + PTR_W'(1);
              state_d   = WDATA_ACK;
            end
          end
        end

        // MSB already on the bus at entry; each later fall presents the next bit
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt + BCNT_W'(1);
          end else if (hold_done) begin
            if (bit_cnt == BCNT_W'(8)) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = RD_ACK;
            end else begin
              sda_oe_d = ~shift[6];
              shift_d  = {shift[5:0], 1'b0};
            end
          end
        end

        // Pointer advances on the ACK clock rise; reload waits for the following fall
        RD_ACK: begin
          if (scl_rise) begin
            ptr_d = ptr + PTR_W'(1);
            if (sda_f) begin
              sda_oe_d = 1'b0;
              state_d  = IGNORE;
            end else begin
              bit_cnt_d = BCNT_W'(1);
            end
          end else if (hold_done && bit_cnt == BCNT_W'(1)) begin
            shift_d   = rd_data[6:0];
            sda_oe_d  = ~rd_data[7];
            bit_cnt_d = '0;
            state_d   = RDATA;
          end
        end

        IGNORE: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

endmodule
